// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg
//   Shared types and constants for the pixel array sequencer:
//   - seq_state_e : top-level frame sequencer states
//   - hs_state_e  : UART launch/done byte handshake states
//   - HDR_BYTE    : frame header byte
//   - frame_bytes : bytes per frame for a given channel count
// Optional feature macro: PIXEL_SEQ_CHECKSUM_EN (adds one trailing XOR byte).
package pixel_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RESET_IV,
        S_RECORDING,
        S_HOLD_IV,
        S_TX_HDR,
        S_ADC_REQ,
        S_ADC_WAIT,
        S_TX_LO,
        S_TX_HI,
        S_TX_CSUM,
        S_TX_END,
        S_GAP
    } seq_state_e;

    typedef enum logic [1:0] {
        H_IDLE,
        H_SETUP,
        H_LAUNCH,
        H_RELEASE
    } hs_state_e;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    // Header (A5 + seq) plus lo/hi per channel, plus the checksum when enabled.
    function automatic int unsigned frame_bytes(input int unsigned ch_count);
`ifdef PIXEL_SEQ_CHECKSUM_EN
        return 3 + 2 * ch_count;
`else
        return 2 + 2 * ch_count;
`endif
    endfunction

endpackage

// File: rtl/seq_tx_handshake.sv
// seq_tx_handshake
//   Single-byte launch/done handshake toward the UART transmitter.
//   A one-cycle req_i pulse loads data_i; the byte is presented on tx_data_o
//   for a cycle before tx_launch_n_o drops, launch stays low until tx_done_i
//   rises, then released; once tx_done_i falls again a one-cycle ack_o pulse
//   tells the sequencer the byte is finished. tx_data_o holds the byte until
//   the next request.
// Ports:
//   clk_in, reset      clock, async active-low reset
//   req_i, data_i      byte request pulse and byte value (from sequencer)
//   ack_o              byte complete pulse (to sequencer)
//   tx_launch_n_o      UART launch, active low
//   tx_data_o          UART byte
//   tx_done_i          UART byte complete
module seq_tx_handshake
    import pixel_seq_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic       req_i,
    input  logic [7:0] data_i,
    output logic       ack_o,
    output logic       tx_launch_n_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i
);

    hs_state_e  state_q;
    logic       ack_q;
    logic       launch_n_q;
    logic [7:0] data_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= H_IDLE;
            ack_q      <= 1'b0;
            launch_n_q <= 1'b1;
            data_q     <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                H_IDLE: begin
                    if (req_i) begin
                        data_q  <= data_i;
                        state_q <= H_SETUP;
                    end
                end
                // Data has been on the pins for a cycle before launch drops.
                H_SETUP: begin
                    launch_n_q <= 1'b0;
                    state_q    <= H_LAUNCH;
                end
                H_LAUNCH: begin
                    if (tx_done_i) begin
                        launch_n_q <= 1'b1;
                        state_q    <= H_RELEASE;
                    end
                end
                H_RELEASE: begin
                    if (!tx_done_i) begin
                        ack_q   <= 1'b1;
                        state_q <= H_IDLE;
                    end
                end
                default: state_q <= H_IDLE;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign tx_launch_n_o = launch_n_q;
    assign tx_data_o     = data_q;

endmodule

// File: rtl/pixel_array_sequencer.sv
// pixel_array_sequencer
//   Runs reset / integrate / hold on the shared integrator bank, then
//   digitises CH_COUNT channels through the ADC driver start/CS handshake and
//   streams each frame out as bytes: A5, seq, {lo, hi} per channel
//   (plus an XOR checksum byte when PIXEL_SEQ_CHECKSUM_EN is defined).
//   Single-shot on a start_n falling edge, or back-to-back with `continuous`.
// Ports:
//   clk_in, reset            clock, async active-low reset
//   start_n                  async start button, active low
//   continuous, t_frame_sel  auto re-arm, long/short integration select
//   reset_iv_n, hold_iv_n    integrator controls, active low
//   d_out                    pixel drive strobe
//   adc_ch, adc_start_n      ADC channel address, conversion request
//   adc_cs_n, adc_data       ADC busy (low = converting), result
//   tx_launch_n, tx_data     UART launch and byte
//   tx_done                  UART byte complete
//   busy, err_tmo            frame in progress, sticky ADC timeout
// Configuration macro: PIXEL_SEQ_CHECKSUM_EN.
module pixel_array_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int CH_COUNT = 4,
    parameter int CNT_W    = 32,
    parameter int T_SHORT  = 5_000_000,
    parameter int T_LONG   = 50_000_000,
    parameter int T_GUARD  = 2000,
    parameter int ADC_TMO  = 256
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start_n,
    input  logic        continuous,
    input  logic        t_frame_sel,
    output logic        reset_iv_n,
    output logic        hold_iv_n,
    output logic        d_out,
    output logic [2:0]  adc_ch,
    output logic        adc_start_n,
    input  logic        adc_cs_n,
    input  logic [15:0] adc_data,
    output logic        tx_launch_n,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        err_tmo
);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(T_GUARD - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(ADC_TMO - 1);
    localparam logic [2:0]       CH_LAST    = 3'(CH_COUNT - 1);
    localparam logic [4:0]       FRAME_LAST = 5'(frame_bytes(unsigned'(CH_COUNT)) - 1);

    // ---------------------------------------------------------------
    // start_n synchroniser and falling-edge detect
    // ---------------------------------------------------------------
    logic start_s1_q, start_s2_q, start_s3_q;
    logic start_fall;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            start_s1_q <= 1'b1;
            start_s2_q <= 1'b1;
            start_s3_q <= 1'b1;
        end else begin
            start_s1_q <= start_n;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
        end
    end

    assign start_fall = start_s3_q & ~start_s2_q;

    // ---------------------------------------------------------------
    // Sequencer state
    // ---------------------------------------------------------------
    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             t_long_q;
    logic [2:0]       ch_q;
    logic [7:0]       seq_q;
    logic [7:0]       sample_hi_q;
    logic             hdr_idx_q;
    logic [4:0]       byte_idx_q;
    logic             req_q;
    logic [7:0]       byte_q;
    logic             reset_iv_n_q, hold_iv_n_q, d_out_q, adc_start_n_q;
    logic             busy_q, err_tmo_q;
`ifdef PIXEL_SEQ_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic             tx_ack;
    logic [CNT_W-1:0] t_int_last;
    logic             frame_go;

    assign t_int_last = t_long_q ? LONG_LAST : SHORT_LAST;

    // A frame begins either from a button edge in IDLE or at the end of the
    // inter-frame gap in continuous mode; both paths share the same entry.
    assign frame_go = ((state_q == S_IDLE) && start_fall) ||
                      ((state_q == S_GAP) && (cnt_q == GUARD_LAST));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            t_long_q      <= 1'b0;
            ch_q          <= '0;
            seq_q         <= '0;
            sample_hi_q   <= '0;
            hdr_idx_q     <= 1'b0;
            byte_idx_q    <= '0;
            req_q         <= 1'b0;
            byte_q        <= '0;
            reset_iv_n_q  <= 1'b1;
            hold_iv_n_q   <= 1'b1;
            d_out_q       <= 1'b0;
            adc_start_n_q <= 1'b1;
            busy_q        <= 1'b0;
            err_tmo_q     <= 1'b0;
`ifdef PIXEL_SEQ_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            req_q <= 1'b0;

            if (tx_ack) begin
                byte_idx_q <= byte_idx_q + 5'd1;
`ifdef PIXEL_SEQ_CHECKSUM_EN
                // byte_q still holds the byte that just completed.
                csum_q     <= csum_q ^ byte_q;
`endif
            end

            case (state_q)
                S_IDLE: ;

                S_RESET_IV: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_q      <= S_RECORDING;
                        cnt_q        <= '0;
                        reset_iv_n_q <= 1'b1;
                        d_out_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_RECORDING: begin
                    if (cnt_q == t_int_last) begin
                        state_q     <= S_HOLD_IV;
                        cnt_q       <= '0;
                        hold_iv_n_q <= 1'b0;
                        d_out_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_HOLD_IV: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_q   <= S_TX_HDR;
                        cnt_q     <= '0;
                        d_out_q   <= 1'b0;
                        hdr_idx_q <= 1'b0;
                        req_q     <= 1'b1;
                        byte_q    <= HDR_BYTE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_TX_HDR: begin
                    if (tx_ack) begin
                        if (!hdr_idx_q) begin
                            hdr_idx_q <= 1'b1;
                            req_q     <= 1'b1;
                            byte_q    <= seq_q;
                        end else begin
                            state_q       <= S_ADC_REQ;
                            ch_q          <= '0;
                            cnt_q         <= '0;
                            adc_start_n_q <= 1'b0;
                        end
                    end
                end

                // Request held until the driver shows busy, or the timeout
                // substitutes an all-ones sample and the frame carries on.
                S_ADC_REQ: begin
                    if (!adc_cs_n) begin
                        adc_start_n_q <= 1'b1;
                        state_q       <= S_ADC_WAIT;
                    end else if (cnt_q == TMO_LAST) begin
                        adc_start_n_q <= 1'b1;
                        err_tmo_q     <= 1'b1;
                        sample_hi_q   <= 8'hFF;
                        req_q         <= 1'b1;
                        byte_q        <= 8'hFF;
                        state_q       <= S_TX_LO;
                        if (ch_q == CH_LAST) hold_iv_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_ADC_WAIT: begin
                    if (adc_cs_n) begin
                        sample_hi_q <= adc_data[15:8];
                        req_q       <= 1'b1;
                        byte_q      <= adc_data[7:0];
                        state_q     <= S_TX_LO;
                        if (ch_q == CH_LAST) hold_iv_n_q <= 1'b1;
                    end
                end

                S_TX_LO: begin
                    if (tx_ack) begin
                        req_q   <= 1'b1;
                        byte_q  <= sample_hi_q;
                        state_q <= S_TX_HI;
                    end
                end

                S_TX_HI: begin
                    if (tx_ack) begin
                        if (byte_idx_q == FRAME_LAST) begin
                            state_q <= S_TX_END;
`ifdef PIXEL_SEQ_CHECKSUM_EN
                        end else if (ch_q == CH_LAST) begin
                            req_q   <= 1'b1;
                            byte_q  <= csum_q ^ byte_q;
                            state_q <= S_TX_CSUM;
`endif
                        end else begin
                            ch_q          <= ch_q + 3'd1;
                            cnt_q         <= '0;
                            adc_start_n_q <= 1'b0;
                            state_q       <= S_ADC_REQ;
                        end
                    end
                end

                S_TX_CSUM: begin
                    if (tx_ack) state_q <= S_TX_END;
                end

                S_TX_END: begin
                    seq_q <= seq_q + 8'd1;
                    cnt_q <= '0;
                    if (continuous) begin
                        state_q <= S_GAP;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                S_GAP: cnt_q <= cnt_q + 1'b1;

                default: state_q <= S_IDLE;
            endcase

            // Frame entry overrides the per-state updates above.
            if (frame_go) begin
                state_q      <= S_RESET_IV;
                cnt_q        <= '0;
                t_long_q     <= t_frame_sel;
                byte_idx_q   <= '0;
                reset_iv_n_q <= 1'b0;
                d_out_q      <= 1'b1;
                busy_q       <= 1'b1;
                err_tmo_q    <= 1'b0;
`ifdef PIXEL_SEQ_CHECKSUM_EN
                csum_q       <= '0;
`endif
            end
        end
    end

    seq_tx_handshake u_tx (
        .clk_in        (clk_in),
        .reset         (reset),
        .req_i         (req_q),
        .data_i        (byte_q),
        .ack_o         (tx_ack),
        .tx_launch_n_o (tx_launch_n),
        .tx_data_o     (tx_data),
        .tx_done_i     (tx_done)
    );

    assign reset_iv_n  = reset_iv_n_q;
    assign hold_iv_n   = hold_iv_n_q;
    assign d_out       = d_out_q;
    assign adc_ch      = ch_q;
    assign adc_start_n = adc_start_n_q;
    assign busy        = busy_q;
    assign err_tmo     = err_tmo_q;

endmodule

// File: tb/tb_pixel_array_sequencer.sv
module tb_pixel_array_sequencer;
    import pixel_seq_pkg::*;

    localparam int FL = int'(frame_bytes(2));

    logic        clk_in, reset, start_n, continuous, t_frame_sel;
    logic        reset_iv_n, hold_iv_n, d_out, adc_start_n, adc_cs_n;
    logic [2:0]  adc_ch;
    logic [15:0] adc_data;
    logic        tx_launch_n, tx_done, busy, err_tmo;
    logic [7:0]  tx_data;

    pixel_array_sequencer #(
        .CH_COUNT(2), .CNT_W(32), .T_SHORT(20), .T_LONG(40), .T_GUARD(4), .ADC_TMO(8)
    ) dut (
        .clk_in(clk_in), .reset(reset), .start_n(start_n), .continuous(continuous),
        .t_frame_sel(t_frame_sel), .reset_iv_n(reset_iv_n), .hold_iv_n(hold_iv_n),
        .d_out(d_out), .adc_ch(adc_ch), .adc_start_n(adc_start_n), .adc_cs_n(adc_cs_n),
        .adc_data(adc_data), .tx_launch_n(tx_launch_n), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .err_tmo(err_tmo)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rx_count = 0;
    int busy_falls = 0;
    logic fail_ch1 = 1'b0;
    logic [15:0] adc_tbl [2] = '{16'h0123, 16'h0456};

    logic [7:0] exp_q[$];
    int         exp_rst_q[$];
    int         exp_rec_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] seq, input logic [15:0] s0,
                              input logic [15:0] s1, input int rec);
        logic [7:0] b [6];
        b = '{8'hA5, seq, s0[7:0], s0[15:8], s1[7:0], s1[15:8]};
        foreach (b[i]) exp_q.push_back(b[i]);
`ifdef PIXEL_SEQ_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (b[i]) x = x ^ b[i];
            exp_q.push_back(x);
        end
`endif
        exp_rst_q.push_back(4);
        exp_rec_q.push_back(rec);
    endtask

    // ADC driver model: responds to a request unless ch1 is set to hang.
    initial begin
        adc_cs_n = 1'b1;
        adc_data = 16'h0000;
        forever begin
            @(negedge clk_in);
            if (reset === 1'b1 && adc_start_n === 1'b0 && !(fail_ch1 && adc_ch == 3'd1)) begin
                int ch;
                ch = int'(adc_ch);
                repeat (2) @(negedge clk_in);
                adc_cs_n = 1'b0;
                repeat (3) @(negedge clk_in);
                adc_data = adc_tbl[ch];
                adc_cs_n = 1'b1;
            end
        end
    end

    // UART model and byte scoreboard monitor.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk_in);
            if (reset === 1'b1 && tx_launch_n === 1'b0 && !tx_done) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(tx_data), 32'h1ff);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", rx_count), 32'(tx_data), 32'(e));
                end
                repeat (3) @(negedge clk_in);
                tx_done = 1'b1;
                for (int k = 0; k < 100 && tx_launch_n !== 1'b1; k++) @(negedge clk_in);
                check("launch_release", 32'(tx_launch_n), 32'd1);
                @(negedge clk_in);
                tx_done = 1'b0;
            end
        end
    end

    // Phase-length monitor: reset_iv_n low run, then recording run.
    initial begin
        int run, mode;
        run = 0; mode = 0;
        forever begin
            @(negedge clk_in);
            if (reset !== 1'b1) begin
                mode = 0; run = 0;
            end else if (mode == 0) begin
                if (reset_iv_n === 1'b0) begin run = 1; mode = 1; end
            end else if (mode == 1) begin
                if (reset_iv_n === 1'b0) run++;
                else begin
                    check("reset_iv_len", 32'(run), exp_rst_q.size() ? 32'(exp_rst_q.pop_front()) : 32'hdead);
                    run = 1; mode = 2;
                end
            end else begin
                if (hold_iv_n === 1'b0) begin
                    check("recording_len", 32'(run), exp_rec_q.size() ? 32'(exp_rec_q.pop_front()) : 32'hdead);
                    mode = 0;
                end else run++;
            end
        end
    end

    initial begin
        logic pb;
        pb = 1'b0;
        forever begin
            @(negedge clk_in);
            if (reset === 1'b1 && pb && busy === 1'b0) busy_falls++;
            pb = (reset === 1'b1) && (busy === 1'b1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_reset_iv_n"},  32'(reset_iv_n), 1);
        check({tag, "_hold_iv_n"},   32'(hold_iv_n), 1);
        check({tag, "_d_out"},       32'(d_out), 0);
        check({tag, "_adc_ch"},      32'(adc_ch), 0);
        check({tag, "_adc_start_n"}, 32'(adc_start_n), 1);
        check({tag, "_tx_launch_n"}, 32'(tx_launch_n), 1);
        check({tag, "_tx_data"},     32'(tx_data), 0);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_err_tmo"},     32'(err_tmo), 0);
    endtask

    // Pulse start_n and measure the cycles until RESET_IV shows up.
    task automatic start_frame(input string tag);
        int lat;
        lat = 0;
        @(negedge clk_in);
        start_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            lat++;
            if (reset_iv_n === 1'b0) break;
        end
        start_n = 1'b1;
        check({tag, "_start_latency"}, 32'(lat), 3);
        check({tag, "_busy_high"}, 32'(busy), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk_in); n++; end
        check({tag, "_back_to_idle"}, 32'(busy), 0);
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (rx_count < target && n < budget) begin @(negedge clk_in); n++; end
        check({tag, "_bytes_seen"}, 32'(rx_count >= target), 1);
    endtask

    initial begin
        int bf0, base;
        reset = 1'b0; start_n = 1'b1; continuous = 1'b0; t_frame_sel = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (3) @(negedge clk_in);

        // A: short integration, seq 00
        bf0 = busy_falls;
        push_frame(8'h00, 16'h0123, 16'h0456, 20);
        start_frame("A");
        wait_idle("A", 1000);
        check("A_busy_falls", 32'(busy_falls - bf0), 1);
        check("A_hold_released", 32'(hold_iv_n), 1);

        // B: long integration latched at start, select flipped mid-frame
        t_frame_sel = 1'b1;
        push_frame(8'h01, 16'h0123, 16'h0456, 40);
        start_frame("B");
        t_frame_sel = 1'b0;
        wait_idle("B", 1000);

        // C: ch1 never answers -> FF FF and sticky timeout
        fail_ch1 = 1'b1;
        push_frame(8'h02, 16'h0123, 16'hFFFF, 20);
        start_frame("C");
        wait_idle("C", 1000);
        check("C_err_tmo_set", 32'(err_tmo), 1);
        repeat (5) @(negedge clk_in);
        check("C_err_tmo_sticky", 32'(err_tmo), 1);
        fail_ch1 = 1'b0;

        // D: timeout flag clears at next start; reset lands during TX_LO
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03); exp_q.push_back(8'h23);
        exp_rst_q.push_back(4); exp_rec_q.push_back(20);
        base = rx_count;
        start_frame("D");
        check("D_err_tmo_cleared", 32'(err_tmo), 0);
        wait_rx("D", base + 3, 1000);
        #1;
        check("D_launch_before_reset", 32'(tx_launch_n), 0);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (5) @(negedge clk_in);
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        check("D_queue_drained", 32'(exp_q.size()), 0);

        // E: continuous, seq restarts at 00, dropped during frame 3
        continuous = 1'b1;
        bf0 = busy_falls;
        base = rx_count;
        push_frame(8'h00, 16'h0123, 16'h0456, 20);
        push_frame(8'h01, 16'h0123, 16'h0456, 20);
        push_frame(8'h02, 16'h0123, 16'h0456, 20);
        start_frame("E");
        wait_rx("E", base + 2 * FL + 2, 3000);
        continuous = 1'b0;
        wait_idle("E", 3000);
        check("E_busy_falls", 32'(busy_falls - bf0), 1);
        check("E_byte_count", 32'(rx_count - base), 32'(3 * FL));

        repeat (10) @(negedge clk_in);
        check("bytes_left", 32'(exp_q.size()), 0);
        check("rst_phases_left", 32'(exp_rst_q.size()), 0);
        check("rec_phases_left", 32'(exp_rec_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
